// File: rtl/mux_sel_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_seq
//  Purpose  : Registered N-channel, W-bit switch-bank multiplexer. A raw
//             pushbutton is synchronised and debounced; each clean press steps
//             the channel index. In auto-scan mode the index instead advances
//             on a free-running timer. led shows the selected W-bit slice of
//             sw and sel reports the active channel.
//  Ports    : clk   - system clock, rising edge
//             rst   - synchronous reset, active-high
//             sw    - switch bank, channel k = sw[k*W +: W]
//             pba   - raw pushbutton (asynchronous, bouncy, active-high)
//             scan  - 1 = auto-scan, 0 = manual step (quasi-static)
//             led   - registered copy of the selected channel
//             sel   - current channel index
//  Revision : 1.0  initial release
// ============================================================================
module mux_sel_seq #(
    parameter  int W           = 4,
    parameter  int N           = 2,
    parameter  int DEB_CYCLES  = 16,
    parameter  int SCAN_PERIOD = 50000000,
    localparam int SELW        = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W*N-1:0]    sw,
    input  logic              pba,
    input  logic              scan,
    output logic [W-1:0]      led,
    output logic [SELW-1:0]   sel
);

    // Debounce counter must hold DEB_CYCLES-1; scan timer holds SCAN_PERIOD-1.
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int TW  = $clog2(SCAN_PERIOD);

    localparam logic [DCW-1:0]  c_DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]   c_SCAN_LAST = TW'(SCAN_PERIOD - 1);
    localparam logic [SELW-1:0] c_SEL_LAST  = SELW'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            sync1_q,    sync1_d;
    logic            sync2_q,    sync2_d;
    logic            db_level_q, db_level_d;
    logic            db_prev_q,  db_prev_d;
    logic            press_q,    press_d;
    logic [DCW-1:0]  db_cnt_q,   db_cnt_d;
    logic [TW-1:0]   timer_q,    timer_d;
    logic [SELW-1:0] sel_q,      sel_d;
    logic [W-1:0]    led_q,      led_d;

    logic            step;
    logic [W-1:0]    chan_sel;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Two-flop synchroniser on the raw button.
        sync1_d = pba;
        sync2_d = sync1_q;

        // Debounce: count consecutive cycles where the synchronised level
        // disagrees with the accepted level. Any agreement restarts the count,
        // so only a run of DEB_CYCLES disagreeing samples flips the level.
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == c_DEB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DCW'(1);
            end
        end

        // Registered rising-edge detect: one-cycle strobe per accepted press.
        db_prev_d = db_level_q;
        press_d   = db_level_q & ~db_prev_q;

        // Channel advance source: the scan timer when scanning (presses are
        // ignored), otherwise the press strobe. Timer is held at 0 outside
        // scan mode so entering scan always starts a full period.
        timer_d = '0;
        step    = press_q;
        if (scan) begin
            step = 1'b0;
            if (timer_q == c_SCAN_LAST) begin
                step = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        // Explicit wrap so non-power-of-2 channel counts never overflow.
        sel_d = sel_q;
        if (step) begin
            sel_d = (sel_q == c_SEL_LAST) ? '0 : sel_q + SELW'(1);
        end

        // Output mux uses the pre-edge index.
        chan_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_q == SELW'(k)) begin
                chan_sel = sw[k*W +: W];
            end
        end
        led_d = chan_sel;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            press_q    <= 1'b0;
            db_cnt_q   <= '0;
            timer_q    <= '0;
            sel_q      <= '0;
            led_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_prev_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            timer_q    <= timer_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
        end
    end

    assign led = led_q;
    assign sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sel_seq
//  Purpose  : Self-checking bench for mux_sel_seq. Three instances with
//             different W/N/DEB_CYCLES share one clock and reset; a
//             behavioural model tracks each one from pushbutton history,
//             scan-mode run length and channel selection rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_sel_seq;

    localparam int NI   = 3;
    localparam int W0   = 4, N0 = 2, D0 = 4;
    localparam int W1   = 2, N1 = 3, D1 = 4;
    localparam int W2   = 4, N2 = 4, D2 = 3;
    localparam int SP   = 5;
    localparam int HMAX = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [7:0]    sw0;
    logic [5:0]    sw1;
    logic [15:0]   sw2;
    logic [NI-1:0] pba;
    logic [NI-1:0] scan;
    logic [3:0]    led0, led2;
    logic [1:0]    led1;
    logic          sel0;
    logic [1:0]    sel1, sel2;

    mux_sel_seq #(.W(W0), .N(N0), .DEB_CYCLES(D0), .SCAN_PERIOD(SP)) u0 (
        .clk(clk), .rst(rst), .sw(sw0), .pba(pba[0]), .scan(scan[0]),
        .led(led0), .sel(sel0));
    mux_sel_seq #(.W(W1), .N(N1), .DEB_CYCLES(D1), .SCAN_PERIOD(SP)) u1 (
        .clk(clk), .rst(rst), .sw(sw1), .pba(pba[1]), .scan(scan[1]),
        .led(led1), .sel(sel1));
    mux_sel_seq #(.W(W2), .N(N2), .DEB_CYCLES(D2), .SCAN_PERIOD(SP)) u2 (
        .clk(clk), .rst(rst), .sw(sw2), .pba(pba[2]), .scan(scan[2]),
        .led(led2), .sel(sel2));

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    //   * hist holds the raw button value seen at each edge.
    //   * The accepted level flips at edge t when the synchronised samples
    //     for the last DEB edges (raw samples t-2 .. t-1-DEB) all disagree
    //     with it and all those edges come after the previous flip/reset.
    //   * A rise accepted at edge E steps the channel at edge E+2.
    //   * In scan mode the channel steps on every SP-th consecutive scan edge.
    // ------------------------------------------------------------------
    int pw [NI] = '{W0, W1, W2};
    int pn [NI] = '{N0, N1, N2};
    int pd [NI] = '{D0, D1, D2};

    bit hist [NI][HMAX];
    int edge_n = 0;
    int db        [NI];
    int last_flip [NI];
    int rise_t    [NI];
    int scan_run  [NI];
    int m_sel     [NI];
    int m_led     [NI];
    bit chk_en = 1'b0;

    function automatic int sw_of(input int i);
        case (i)
            0:       return int'(sw0);
            1:       return int'(sw1);
            default: return int'(sw2);
        endcase
    endfunction

    task automatic model_step(input int i);
        int t;
        int idx;
        bit ok;
        bit press;
        bit adv;
        t = edge_n;
        if (rst) begin
            hist[i][t] = 1'b0;
            if (t > 0) hist[i][t-1] = 1'b0;
            db[i]        = 0;
            last_flip[i] = t;
            rise_t[i]    = -100;
            scan_run[i]  = 0;
            m_sel[i]     = 0;
            m_led[i]     = 0;
            return;
        end
        hist[i][t] = pba[i];
        m_led[i] = (sw_of(i) >> (m_sel[i] * pw[i])) & ((1 << pw[i]) - 1);

        press = (rise_t[i] == t - 2);

        ok = (last_flip[i] <= t - pd[i]);
        for (int k = 0; k < pd[i]; k++) begin
            idx = t - 2 - k;
            if (idx < 0) ok = 1'b0;
            else if (int'(hist[i][idx]) == db[i]) ok = 1'b0;
        end
        if (ok) begin
            db[i]        = 1 - db[i];
            last_flip[i] = t;
            if (db[i] == 1) rise_t[i] = t;
        end

        if (scan[i]) begin
            scan_run[i]++;
            adv = ((scan_run[i] % SP) == 0);
        end else begin
            scan_run[i] = 0;
            adv = press;
        end
        if (adv) m_sel[i] = (m_sel[i] == pn[i] - 1) ? 0 : m_sel[i] + 1;
    endtask

    always @(posedge clk) begin
        if (edge_n < HMAX) begin
            for (int i = 0; i < NI; i++) model_step(i);
            edge_n++;
            chk_en = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("m0_led", {28'b0, led0}, m_led[0]);
            check_eq("m0_sel", {31'b0, sel0}, m_sel[0]);
            check_eq("m1_led", {30'b0, led1}, m_led[1]);
            check_eq("m1_sel", {30'b0, sel1}, m_sel[1]);
            check_eq("m2_led", {28'b0, led2}, m_led[2]);
            check_eq("m2_sel", {30'b0, sel2}, m_sel[2]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int i, input int hold, input int gap);
        pba[i] = 1'b1;
        tick(hold);
        pba[i] = 1'b0;
        tick(gap);
    endtask

    int exp_wsel [4] = '{1, 2, 0, 1};
    int exp_wled [4] = '{2, 3, 1, 2};

    initial begin
        int  e0;
        int  n;
        bit  done;
        logic [7:0] v;

        rst  = 1'b1;
        sw0  = 8'hA5;
        sw1  = '0;
        sw2  = 16'h3210;
        pba  = '0;
        scan = '0;
        e0   = 0;

        // Reset: outputs held at 0, first channel appears one edge after release.
        tick(3);
        check_eq("rst_led", {28'b0, led0}, 32'h0);
        check_eq("rst_sel", {31'b0, sel0}, 32'h0);
        rst = 1'b0;
        tick(1);
        check_eq("rst_release_led", {28'b0, led0}, 32'h5);

        // Press-to-sel latency.
        pba[0] = 1'b1;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (int'(sel0) != e0) done = 1'b1;
        end
        check_eq("press_latency", n, D0 + 4);
        e0 ^= 1;
        tick(5);
        pba[0] = 1'b0;
        tick(10);
        check_eq("latency_led", {28'b0, led0}, (e0 != 0) ? sw0[7:4] : sw0[3:0]);

        // Manual stepping across every switch pattern.
        for (int s = 0; s < 256; s++) begin
            v = 8'(s);
            sw0 = v;
            press(0, 10, 10);
            e0 ^= 1;
            check_eq("sweep_sel", {31'b0, sel0}, e0);
            check_eq("sweep_led", {28'b0, led0}, (e0 != 0) ? v[7:4] : v[3:0]);
        end

        // Bounce then a stable hold: exactly one step.
        pba[0] = 1'b1; tick(1);
        pba[0] = 1'b0; tick(1);
        pba[0] = 1'b1; tick(1);
        pba[0] = 1'b0; tick(1);
        pba[0] = 1'b1; tick(10);
        pba[0] = 1'b0; tick(12);
        e0 ^= 1;
        check_eq("bounce_sel", {31'b0, sel0}, e0);
        // Pulse shorter than the debounce window: no step.
        press(0, 3, 12);
        check_eq("short_pulse_sel", {31'b0, sel0}, e0);

        // Reset during an in-progress debounce.
        if (e0 == 0) begin
            press(0, 10, 10);
            e0 = 1;
        end
        check_eq("pre_rst_sel", {31'b0, sel0}, 32'h1);
        pba[0] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_sel", {31'b0, sel0}, 32'h0);
        check_eq("mid_rst_led", {28'b0, led0}, 32'h0);
        pba[0] = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(20);
        check_eq("post_rst_sel", {31'b0, sel0}, 32'h0);
        e0 = 0;

        // Wrap with three channels.
        sw1 = 6'b11_10_01;
        for (int j = 0; j < 4; j++) begin
            press(1, 10, 10);
            check_eq("wrap_sel", {30'b0, sel1}, exp_wsel[j]);
            check_eq("wrap_led", {30'b0, led1}, exp_wled[j]);
        end

        // Scan mode with a press held during it (ignored).
        scan[2] = 1'b1;
        pba[2]  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(SP);
            if (k == 2) pba[2] = 1'b0;
            check_eq("scan_sel", {30'b0, sel2}, k % N2);
        end
        scan[2] = 1'b0;
        tick(15);
        check_eq("scan_freeze_sel", {30'b0, sel2}, 32'h1);

        // Randomised traffic on all instances, checked by the model.
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 699) == 0);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 7) == 0)   pba[i]  = ~pba[i];
                if ($urandom_range(0, 299) == 0) scan[i] = ~scan[i];
            end
            if ($urandom_range(0, 15) == 0) sw0 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) sw1 = 6'($urandom);
            if ($urandom_range(0, 15) == 0) sw2 = 16'($urandom);
        end
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_sel_seq.md
Name: mux_sel_seq

Overview:
- Registered N-channel, W-bit switch-bank multiplexer for the board's sw/pba/led path.
- Generalises the 2-channel, pushbutton-selected 4-bit mux.
- Raw pushbutton pba is synchronised and debounced. Each clean press steps the channel index.
- Optional auto-scan mode rotates through channels on a timer.
- led shows the selected W-bit slice of sw; sel shows the active channel index.

Parameters:
- W, 4, bits per channel (W >= 1)
- N, 2, number of channels (N >= 2)
- DEB_CYCLES, 16, consecutive stable cycles required to accept a new button level (>= 1)
- SCAN_PERIOD, 50000000, cycles between channel advances in scan mode (>= 2)
- SELW, $clog2(N), width of the sel output (derived, not overridden)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- sw  input  W*N  switch bank; channel k = sw[k*W +: W]
- pba  input  1  raw pushbutton, asynchronous, bouncy, active-high
- scan  input  1  1 = auto-scan mode, 0 = manual step mode; quasi-static, used unsynchronised
- led  output  W  registered copy of the selected channel
- sel  output  SELW  current channel index

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge), all on that edge:
  - led=0, sel=0
  - synchroniser flops=0, debounced level=0
  - debounce counter=0, scan timer=0
  - rst overrides every other event in the same cycle, including mid-debounce and mid-scan.
- Synchroniser: 2-flop chain on pba. Output pba_s lags pba by 2 edges.
- Debounce:
  - Counter increments while pba_s != db_level and clears when they are equal.
  - When the counter reaches DEB_CYCLES, on that edge db_level <= pba_s and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never change db_level.
- Press pulse: one-cycle strobe when db_level rises 0->1 (registered edge detect). Release (1->0) produces no strobe.
- Channel index (sel), manual mode (scan=0):
  - On press, sel <= sel+1; when sel == N-1, sel <= 0 (wrap).
  - Scan timer held at 0.
- Channel index (sel), scan mode (scan=1):
  - Timer counts 0..SCAN_PERIOD-1.
  - At terminal count the timer returns to 0 and sel advances with the same wrap rule.
  - Press strobes are ignored.
  - scan 1->0 clears the timer on the next edge; sel keeps its value.
  - scan 0->1 starts the timer from 0.
- Output:
  - Every cycle led <= sw[sel*W +: W], using the pre-edge sel.
  - sw change -> led updates after 1 edge.
  - sel change -> led shows the new channel 1 edge after sel.
- Press latency: if pba rises cleanly and stays high, sel increments exactly DEB_CYCLES+4 edges after the first edge sampling pba=1, and led follows 1 edge later.
  - Breakdown: 2 sync + DEB_CYCLES debounce + 1 edge detect + 1 sel register.
- Non-power-of-2 N: sel never exceeds N-1; wrap is explicit, not modular overflow.
- Held button: exactly one step per press, no auto-repeat.

Test Plan:
- Reset: drive sw=8'hA5 with rst=1 for 3 cycles -> led=0, sel=0 during reset. One edge after rst falls, led=4'h5.
- Manual stepping, W=4, N=2, DEB_CYCLES=4, scan=0:
  - sweep sw over all 256 values.
  - For each value, issue a clean press -> sel toggles 0->1->0 and led matches sw[3:0]/sw[7:4] on every sel value.
  - Press-to-sel latency is exactly 8 edges.
- Bounce rejection, DEB_CYCLES=4: pba toggles 1,0,1,0 each cycle, then holds high 10 cycles -> exactly one sel increment. A 3-cycle-wide pulse -> no increment.
- Wrap with non-power-of-2 count, N=3, W=2: 4 presses with sw=6'b11_10_01 -> sel sequence 1,2,0,1 and led 2'b10, 2'b11, 2'b01, 2'b10.
- Scan mode, N=4, SCAN_PERIOD=5:
  - scan=1 -> sel advances every 5 cycles 0,1,2,3,0. Presses during scan leave sel unchanged.
  - Clearing scan freezes sel.
- Reset mid-operation:
  - assert rst during an in-progress debounce with sel=1 -> sel=0 and led=0.
  - A press begun before reset produces no increment after reset.
